// File: rtl/ibex_rvfi_trace_streamer.sv
// ibex_rvfi_trace_streamer
//
// Captures retired instructions from the core RVFI port into a small FIFO and
// serializes each entry into a packet of 32-bit words on a valid/ready stream:
//   HDR, PC, INSN, and WDATA only when the instruction wrote a register (rd != 0).
// Retirements arriving while the FIFO is full are dropped and counted. The
// number of drops since the last captured entry is carried in that entry's
// header so a trace consumer can see where gaps occurred.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   rvfi_*_i                 retirement record from the core (valid strobe + fields)
//   trace_en_i               capture enable; queued entries still drain when low
//   trace_valid_o/ready_i    output word handshake
//   trace_data_o/last_o      output word, last word of the current packet
//   drop_cnt_o               saturating count of dropped retirements
//   overflow_o               sticky flag, set on the first drop after reset
//   fifo_level_o             number of occupied FIFO entries

module ibex_rvfi_trace_streamer #(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      rvfi_valid_i,
    input  logic [31:0]               rvfi_pc_rdata_i,
    input  logic [31:0]               rvfi_insn_i,
    input  logic                      rvfi_trap_i,
    input  logic                      rvfi_intr_i,
    input  logic [1:0]                rvfi_mode_i,
    input  logic [4:0]                rvfi_rd_addr_i,
    input  logic [31:0]               rvfi_rd_wdata_i,

    input  logic                      trace_en_i,

    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [31:0]               trace_data_o,
    output logic                      trace_last_o,

    output logic [DropCntWidth-1:0]   drop_cnt_o,
    output logic                      overflow_o,
    output logic [$clog2(Depth):0]    fifo_level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_PC    = 3'd2;
    localparam logic [2:0] S_INSN  = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd_addr;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        logic [9:0]  lost;
    } entry_t;

    entry_t                  mem [Depth];
    logic [PtrW-1:0]         wr_ptr;
    logic [PtrW-1:0]         rd_ptr;
    logic [LvlW-1:0]         level;
    logic [9:0]              lost_pending;
    logic [DropCntWidth-1:0] drop_cnt;
    logic                    overflow;

    logic [2:0]              state_q;
    logic [2:0]              state_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    capture;
    logic                    wr_en;
    logic                    drop;
    logic                    word_acc;
    logic                    pop;
    logic                    head_has_rd;
    entry_t                  head;
    entry_t                  new_entry;
    logic [31:0]             hdr_word;

    assign fifo_full  = (level == LvlW'(Depth));
    assign fifo_empty = (level == '0);

    // A full FIFO drops the incoming retirement even if the head is popped at
    // the same edge: the decision uses the level registered at cycle start.
    assign capture = rvfi_valid_i && trace_en_i;
    assign wr_en   = capture && !fifo_full;
    assign drop    = capture && fifo_full;

    assign head        = mem[rd_ptr];
    assign head_has_rd = (head.rd_addr != 5'd0);

    assign word_acc = trace_valid_o && trace_ready_i;
    assign pop      = word_acc && trace_last_o;

    assign new_entry = '{
        pc:      rvfi_pc_rdata_i,
        insn:    rvfi_insn_i,
        wdata:   rvfi_rd_wdata_i,
        rd_addr: rvfi_rd_addr_i,
        trap:    rvfi_trap_i,
        intr:    rvfi_intr_i,
        mode:    rvfi_mode_i,
        lost:    lost_pending
    };

    assign hdr_word = {4'hA, head.trap, head.intr, head.mode, head.rd_addr,
                       head_has_rd, head.lost, 8'h00};

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lost_pending <= '0;
            drop_cnt     <= '0;
            overflow     <= 1'b0;
        end else begin
            if (wr_en) begin
                lost_pending <= '0;
            end else if (drop && lost_pending != '1) begin
                lost_pending <= lost_pending + 1'b1;
            end
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // At packet end the next packet starts immediately if any entry remains
    // after the pop, including one written at that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_HDR;
            S_HDR:   if (word_acc) state_d = S_PC;
            S_PC:    if (word_acc) state_d = S_INSN;
            S_INSN: begin
                if (word_acc) begin
                    if (head_has_rd) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = (level > LvlW'(1) || wr_en) ? S_HDR : S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                if (word_acc) begin
                    state_d = (level > LvlW'(1) || wr_en) ? S_HDR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output words are taken straight from the head entry, which cannot change
    // until the packet's last word is accepted, so they hold during stalls.
    always_comb begin
        trace_valid_o = 1'b0;
        trace_data_o  = '0;
        trace_last_o  = 1'b0;
        case (state_q)
            S_HDR: begin
                trace_valid_o = 1'b1;
                trace_data_o  = hdr_word;
            end
            S_PC: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.pc;
            end
            S_INSN: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.insn;
                trace_last_o  = !head_has_rd;
            end
            S_WDATA: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.wdata;
                trace_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign drop_cnt_o   = drop_cnt;
    assign overflow_o   = overflow;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_ibex_rvfi_trace_streamer.sv
// Self-checking bench for ibex_rvfi_trace_streamer: directed scenarios followed
// by a randomized phase, all checked against a packet-level queue model.

module tb_ibex_rvfi_trace_streamer;

    localparam int DEPTH = 8;
    localparam int DCW   = 16;

    logic        clk;
    logic        rst_i;
    logic        rvfi_valid_i;
    logic [31:0] rvfi_pc_rdata_i;
    logic [31:0] rvfi_insn_i;
    logic        rvfi_trap_i;
    logic        rvfi_intr_i;
    logic [1:0]  rvfi_mode_i;
    logic [4:0]  rvfi_rd_addr_i;
    logic [31:0] rvfi_rd_wdata_i;
    logic        trace_en_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic [DCW-1:0] drop_cnt_o;
    logic        overflow_o;
    logic [$clog2(DEPTH):0] fifo_level_o;

    ibex_rvfi_trace_streamer #(
        .Depth        (DEPTH),
        .DropCntWidth (DCW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .rvfi_valid_i    (rvfi_valid_i),
        .rvfi_pc_rdata_i (rvfi_pc_rdata_i),
        .rvfi_insn_i     (rvfi_insn_i),
        .rvfi_trap_i     (rvfi_trap_i),
        .rvfi_intr_i     (rvfi_intr_i),
        .rvfi_mode_i     (rvfi_mode_i),
        .rvfi_rd_addr_i  (rvfi_rd_addr_i),
        .rvfi_rd_wdata_i (rvfi_rd_wdata_i),
        .trace_en_i      (trace_en_i),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_data_o    (trace_data_o),
        .trace_last_o    (trace_last_o),
        .drop_cnt_o      (drop_cnt_o),
        .overflow_o      (overflow_o),
        .fifo_level_o    (fifo_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        int          lost;
    } ent_t;

    ent_t        mq[$];
    int          widx;
    int          m_lost;
    int          m_drop;
    int          m_ovf;
    int          n_tests;
    int          n_fail;
    int          acc_words;
    int          bubbles;
    int          n_pkts;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] last_hdr;

    function automatic int pkt_len(ent_t e);
        return (e.rd != 5'd0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] pkt_word(ent_t e, int k);
        logic [9:0] lost10;
        lost10 = 10'(e.lost);
        case (k)
            0:       return {4'hA, e.trap, e.intr, e.mode, e.rd, (e.rd != 5'd0), lost10, 8'h00};
            1:       return e.pc;
            2:       return e.insn;
            default: return e.wdata;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the
    // model across the rising edge using the inputs held during the cycle.
    task automatic tick();
        bit          acc;
        bit          cap;
        bit          full;
        logic [31:0] d;
        ent_t        e;
        @(negedge clk);
        d = trace_data_o;
        check("level", 64'(fifo_level_o), 64'(mq.size()));
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        if (prev_stall) begin
            check("stall_valid", 64'(trace_valid_o), 64'd1);
            check("stall_data", 64'(d), 64'(prev_data));
            check("stall_last", 64'(trace_last_o), 64'(prev_last));
        end
        if (mq.size() == 0) begin
            check("idle_valid", 64'(trace_valid_o), 64'd0);
        end
        acc = trace_valid_o && trace_ready_i && !rst_i;
        if (trace_valid_o && trace_ready_i && mq.size() > 0) begin
            check("word", 64'(d), 64'(pkt_word(mq[0], widx)));
            check("last", 64'(trace_last_o), 64'(widx == pkt_len(mq[0]) - 1));
        end
        if (!trace_valid_o) bubbles++;
        prev_stall = trace_valid_o && !trace_ready_i && !rst_i;
        prev_data  = d;
        prev_last  = trace_last_o;
        cap  = rvfi_valid_i && trace_en_i && !rst_i;
        full = (mq.size() == DEPTH);
        e.pc = rvfi_pc_rdata_i; e.insn = rvfi_insn_i; e.wdata = rvfi_rd_wdata_i;
        e.rd = rvfi_rd_addr_i; e.trap = rvfi_trap_i; e.intr = rvfi_intr_i;
        e.mode = rvfi_mode_i; e.lost = m_lost;
        @(posedge clk);
        #1;
        if (rst_i) begin
            mq.delete();
            widx = 0; m_lost = 0; m_drop = 0; m_ovf = 0;
            prev_stall = 0;
        end else begin
            if (acc && mq.size() > 0) begin
                if (widx == 0) last_hdr = d;
                acc_words++;
                widx++;
                if (widx == pkt_len(mq[0])) begin
                    void'(mq.pop_front());
                    widx = 0;
                    n_pkts++;
                end
            end
            if (cap) begin
                if (full) begin
                    if (m_drop < (1 << DCW) - 1) m_drop++;
                    if (m_lost < 1023) m_lost++;
                    m_ovf = 1;
                end else begin
                    mq.push_back(e);
                    m_lost = 0;
                end
            end
        end
    endtask

    task automatic set_retire(input logic [31:0] pc, input logic [31:0] insn,
                              input logic [4:0] rd, input logic [31:0] wdata);
        rvfi_valid_i    = 1'b1;
        rvfi_pc_rdata_i = pc;
        rvfi_insn_i     = insn;
        rvfi_rd_addr_i  = rd;
        rvfi_rd_wdata_i = wdata;
        rvfi_trap_i     = 1'b0;
        rvfi_intr_i     = 1'b0;
        rvfi_mode_i     = 2'd0;
    endtask

    task automatic drain(input int maxc);
        trace_ready_i = 1'b1;
        rvfi_valid_i  = 1'b0;
        for (int i = 0; i < maxc && mq.size() > 0; i++) tick();
        check("drain_done", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; widx = 0; m_lost = 0; m_drop = 0; m_ovf = 0;
        acc_words = 0; bubbles = 0; n_pkts = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0; last_hdr = '0;
        rst_i = 1'b1; trace_en_i = 1'b1; trace_ready_i = 1'b1;
        set_retire(32'h0, 32'h0, 5'd0, 32'h0);
        rvfi_valid_i = 1'b0;

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_valid", 64'(trace_valid_o), 64'd0);
        check("rst_data", 64'(trace_data_o), 64'd0);
        check("rst_last", 64'(trace_last_o), 64'd0);
        check("rst_level", 64'(fifo_level_o), 64'd0);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        tick();

        // Single retire with rd write, latency of one IDLE->HDR edge
        set_retire(32'h80, 32'h00500093, 5'd1, 32'h5);
        tick();
        rvfi_valid_i = 1'b0;
        check("lat_idle", 64'(trace_valid_o), 64'd0);
        tick();
        check("lat_valid", 64'(trace_valid_o), 64'd1);
        check("lat_hdr", 64'(trace_data_o), 64'hA00C0000);
        acc_words = 0;
        drain(20);
        check("pkt4_words", 64'(acc_words), 64'd4);

        // Retire without rd write: three words, bit 18 clear
        set_retire(32'h84, 32'h00000013, 5'd0, 32'hDEAD);
        tick();
        acc_words = 0;
        drain(20);
        check("pkt3_words", 64'(acc_words), 64'd3);
        check("pkt3_hdr18", 64'(last_hdr[18]), 64'd0);

        // Fill and overflow with output stalled
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_retire(32'h1000 + 32'(i * 4), $urandom, 5'($urandom_range(1, 31)), $urandom);
            tick();
        end
        rvfi_valid_i = 1'b0;
        tick();
        check("ovf_level", 64'(fifo_level_o), 64'd8);
        check("ovf_drop", 64'(drop_cnt_o), 64'd2);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        bubbles = 0;
        n_pkts = 0;
        drain(100);
        check("ovf_pkts", 64'(n_pkts), 64'd8);
        check("ovf_bubbles", 64'(bubbles), 64'd0);
        set_retire(32'h2000, 32'h00100113, 5'd2, 32'h1);
        tick();
        drain(20);
        check("lost_field", 64'(last_hdr[17:8]), 64'd2);

        // Ready toggling during a 4-word packet
        trace_ready_i = 1'b0;
        set_retire(32'h3000, 32'h003081B3, 5'd3, 32'hCAFEF00D);
        tick();
        rvfi_valid_i = 1'b0;
        acc_words = 0;
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            trace_ready_i = ~trace_ready_i;
            tick();
        end
        check("toggle_words", 64'(acc_words), 64'd4);
        check("toggle_done", 64'(mq.size()), 64'd0);

        // Capture disabled
        trace_en_i = 1'b0;
        trace_ready_i = 1'b1;
        n_pkts = 0;
        for (int i = 0; i < 3; i++) begin
            set_retire(32'h4000 + 32'(i * 4), $urandom, 5'd4, $urandom);
            tick();
        end
        rvfi_valid_i = 1'b0;
        tick();
        tick();
        check("dis_pkts", 64'(n_pkts), 64'd0);
        check("dis_drop", 64'(drop_cnt_o), 64'd2);
        trace_en_i = 1'b1;
        set_retire(32'h5000, 32'h00000013, 5'd0, 32'h0);
        tick();
        drain(20);
        check("reen_pkts", 64'(n_pkts), 64'd1);

        // Reset mid-packet after the PC word
        set_retire(32'h6000, 32'h00200113, 5'd2, 32'h77);
        tick();
        rvfi_valid_i = 1'b0;
        for (int i = 0; i < 10 && widx < 2; i++) tick();
        check("mid_widx", 64'(widx), 64'd2);
        rst_i = 1'b1;
        set_retire(32'h6100, 32'h00300193, 5'd3, 32'h88);
        tick();
        rst_i = 1'b0;
        rvfi_valid_i = 1'b0;
        check("mr_valid", 64'(trace_valid_o), 64'd0);
        check("mr_level", 64'(fifo_level_o), 64'd0);
        check("mr_drop", 64'(drop_cnt_o), 64'd0);
        check("mr_ovf", 64'(overflow_o), 64'd0);
        tick();
        set_retire(32'h7000, 32'h00400213, 5'd4, 32'h99);
        tick();
        acc_words = 0;
        drain(20);
        check("mr_fresh_words", 64'(acc_words), 64'd4);

        // Randomized traffic
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int i = 0; i < 1500; i++) begin
                if (i % 50 == 0) rdy_pct = $urandom_range(15, 95);
                rst_i        = ($urandom_range(0, 299) == 0);
                trace_en_i   = ($urandom_range(0, 99) < 85);
                trace_ready_i = ($urandom_range(0, 99) < rdy_pct);
                set_retire($urandom, $urandom,
                           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                           $urandom);
                rvfi_valid_i = ($urandom_range(0, 99) < 60);
                rvfi_trap_i  = 1'($urandom);
                rvfi_intr_i  = 1'($urandom);
                rvfi_mode_i  = 2'($urandom);
                tick();
            end
            rst_i = 1'b0;
            trace_en_i = 1'b0;
            drain(200);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
